// File: rtl/mmio_ctrl_pkg.sv
// Shared constants for mmio_ctrl_pipe: status-slot register map, ERR_STAT layout,
// unpopulated read pattern and the ID version.
package mmio_ctrl_pkg;

  localparam int REG_AW  = 5;
  localparam int BUS_AW  = 11;

  localparam logic [REG_AW-1:0] STAT_ERR = 5'd0;
  localparam logic [REG_AW-1:0] STAT_CNT = 5'd1;
  localparam logic [REG_AW-1:0] STAT_ID  = 5'd2;

  localparam int ERR_VALID_BIT = 31;
  localparam int ERR_WR_BIT    = 30;
  localparam int ERR_PROTO_BIT = 29;
  localparam int ERR_SLOT_LSB  = 8;
  localparam int ERR_SLOT_W    = 6;
  localparam int ERR_REG_LSB   = 0;

  localparam logic [31:0] UNPOP_RD_DATA = 32'hFFFF_FFFF;
  localparam logic [7:0]  ID_VERSION    = 8'h01;

  // Capture word for the first logged error; slot field is the raw addr[10:5].
  function automatic logic [31:0] err_stat_word(input logic wr, input logic proto,
                                                input logic [BUS_AW-1:0] addr);
    logic [31:0] w;
    w = '0;
    w[ERR_VALID_BIT] = 1'b1;
    w[ERR_WR_BIT]    = wr;
    w[ERR_PROTO_BIT] = proto;
    w[ERR_SLOT_LSB +: ERR_SLOT_W] = addr[BUS_AW-1:REG_AW];
    w[ERR_REG_LSB +: REG_AW]      = addr[REG_AW-1:0];
    return w;
  endfunction

endpackage

// File: rtl/mmio_ctrl_pipe_if.sv
// FPro bus between the bridge (master) and mmio_ctrl_pipe (slave):
// request signals in, registered read data and its valid pulse back.
interface mmio_ctrl_pipe_if;
  logic        mmio_cs;
  logic        mmio_wr;
  logic        mmio_rd;
  logic [20:0] mmio_addr;
  logic [31:0] mmio_wr_data;
  logic [31:0] mmio_rd_data;
  logic        mmio_rd_valid;

  modport master (
    output mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
    input  mmio_rd_data, mmio_rd_valid
  );

  modport slave (
    input  mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
    output mmio_rd_data, mmio_rd_valid
  );
endinterface

// File: rtl/mmio_err_log.sv
// Error logger for the status slot: sticky first-error capture in ERR_STAT and a
// saturating ERR_CNT. A clear in the same cycle as an error is applied first.
module mmio_err_log
  import mmio_ctrl_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 err,
  input  logic                 err_wr,
  input  logic                 err_proto,
  input  logic [BUS_AW-1:0]    err_addr,
  output logic [31:0]          err_stat,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [31:0]          stat_q, stat_n;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_n;

  always_comb begin
    stat_n = clr ? '0 : stat_q;
    cnt_n  = clr ? '0 : cnt_q;
    if (err) begin
      if (!stat_n[ERR_VALID_BIT]) begin
        stat_n = err_stat_word(err_wr, err_proto, err_addr);
      end
      if (cnt_n != '1) begin
        cnt_n = cnt_n + ERR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_q <= '0;
      cnt_q  <= '0;
    end else begin
      stat_q <= stat_n;
      cnt_q  <= cnt_n;
    end
  end

  assign err_stat = stat_q;
  assign err_cnt  = cnt_q;

endmodule

// File: rtl/mmio_ctrl_pipe.sv
// FPro MMIO controller: slot decode, registered read return with valid pulse and a
// built-in status slot at N_SLOT-1. Define MMIO_REQ_PIPE_EN to register the request.
module mmio_ctrl_pipe
  import mmio_ctrl_pkg::*;
#(
  parameter int          N_SLOT    = 64,
  parameter logic [63:0] SLOT_MASK = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int          ERR_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  mmio_ctrl_pipe_if.slave       bus,
  output logic [N_SLOT-1:0]     slot_cs_array,
  output logic [N_SLOT-1:0]     slot_mem_rd_array,
  output logic [N_SLOT-1:0]     slot_mem_wr_array,
  output logic [REG_AW-1:0]     slot_reg_addr_array [N_SLOT],
  input  logic [31:0]           slot_rd_data_array  [N_SLOT],
  output logic [31:0]           slot_wr_data_array  [N_SLOT]
);

  localparam int SW = $clog2(N_SLOT);

  logic              req_cs, req_rd, req_wr;
  logic [BUS_AW-1:0] req_addr;
  logic [31:0]       req_wr_data;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^bus.mmio_addr[20:BUS_AW];

`ifdef MMIO_REQ_PIPE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      req_cs      <= 1'b0;
      req_rd      <= 1'b0;
      req_wr      <= 1'b0;
      req_addr    <= '0;
      req_wr_data <= '0;
    end else begin
      req_cs      <= bus.mmio_cs;
      req_rd      <= bus.mmio_rd;
      req_wr      <= bus.mmio_wr;
      req_addr    <= bus.mmio_addr[BUS_AW-1:0];
      req_wr_data <= bus.mmio_wr_data;
    end
  end
`else
  always_comb begin
    req_cs      = bus.mmio_cs;
    req_rd      = bus.mmio_rd;
    req_wr      = bus.mmio_wr;
    req_addr    = bus.mmio_addr[BUS_AW-1:0];
    req_wr_data = bus.mmio_wr_data;
  end
`endif

  logic [SW-1:0]     slot;
  logic [REG_AW-1:0] reg_idx;
  logic              in_range, is_stat, populated;
  logic              access, proto, hit, rd_ok, err_event, stat_clr;

  always_comb begin
    slot      = req_addr[SW+REG_AW-1:REG_AW];
    reg_idx   = req_addr[REG_AW-1:0];
    in_range  = (req_addr >> (SW + REG_AW)) == '0;
    is_stat   = in_range && (slot == SW'(N_SLOT - 1));
    populated = in_range && !is_stat && SLOT_MASK[slot];
    access    = req_cs && (req_rd || req_wr);
    proto     = req_cs && req_rd && req_wr;
    hit       = access && !proto && populated;
    rd_ok     = access && req_rd && !req_wr;
    err_event = access && (proto || (!populated && !is_stat));
    // An rd+wr to ERR_STAT still clears; the protocol error is then logged on top.
    stat_clr  = req_cs && req_wr && is_stat && (reg_idx == STAT_ERR);
  end

  always_comb begin
    slot_cs_array     = '0;
    slot_mem_rd_array = '0;
    slot_mem_wr_array = '0;
    if (hit) begin
      slot_cs_array[slot]     = 1'b1;
      slot_mem_rd_array[slot] = req_rd;
      slot_mem_wr_array[slot] = req_wr;
    end
  end

  for (genvar i = 0; i < N_SLOT; i++) begin : g_bcast
    assign slot_reg_addr_array[i] = reg_idx;
    assign slot_wr_data_array[i]  = req_wr_data;
  end

  logic [31:0]          err_stat;
  logic [ERR_CNT_W-1:0] err_cnt;

  mmio_err_log #(
    .ERR_CNT_W (ERR_CNT_W)
  ) u_err_log (
    .clk       (clk),
    .reset     (reset),
    .clr       (stat_clr),
    .err       (err_event),
    .err_wr    (req_wr),
    .err_proto (proto),
    .err_addr  (req_addr),
    .err_stat  (err_stat),
    .err_cnt   (err_cnt)
  );

  logic [31:0] stat_rd_data, rd_mux;

  always_comb begin
    case (reg_idx)
      STAT_ERR: stat_rd_data = err_stat;
      STAT_CNT: stat_rd_data = 32'(err_cnt);
      STAT_ID:  stat_rd_data = {16'h0, 8'(N_SLOT - 1), ID_VERSION};
      default:  stat_rd_data = '0;
    endcase
  end

  always_comb begin
    if (is_stat)        rd_mux = stat_rd_data;
    else if (populated) rd_mux = slot_rd_data_array[slot];
    else                rd_mux = UNPOP_RD_DATA;
  end

  logic [31:0] rd_data_q;
  logic        rd_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_ok;
      if (rd_ok) rd_data_q <= rd_mux;
    end
  end

  assign bus.mmio_rd_data  = rd_data_q;
  assign bus.mmio_rd_valid = rd_valid_q;

endmodule

// File: doc/mmio_ctrl_pipe.md
Name: mmio_ctrl_pipe

Overview:
Parametrised successor to the FPro MMIO controller used by the mmio_sys subsystems. It decodes FPro bus accesses into N_SLOT slot strobes and registers the read return, adding mmio_rd_valid. Accesses to unpopulated slots, out-of-range addresses and illegal rd+wr requests are captured in a built-in status slot. It sits between the FPro bridge and the slot cores inside each mmio_sys_* top.

Parameters:
N_SLOT, 64, number of slots; power of 2, 4..64; SW = $clog2(N_SLOT).
SLOT_MASK, 64'hFFFF_FFFF_FFFF_FFFF, bit i = 1 means slot i is populated; the bit for slot N_SLOT-1 is ignored.
ERR_CNT_W, 16, width of the saturating error counter (≤ 32).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
mmio_cs  in  1  bus select
mmio_wr  in  1  write request
mmio_rd  in  1  read request
mmio_addr  in  21  word address; bits [10:0] are used
mmio_wr_data  in  32  write data
mmio_rd_data  out  32  registered read data
mmio_rd_valid  out  1  one-cycle pulse; mmio_rd_data is valid in the same cycle
slot_cs_array  out  N_SLOT  per-slot select
slot_mem_rd_array  out  N_SLOT  per-slot read strobe
slot_mem_wr_array  out  N_SLOT  per-slot write strobe
slot_reg_addr_array  out  [N_SLOT] x 5  per-slot register address (mmio_addr[4:0] broadcast)
slot_rd_data_array  in  [N_SLOT] x 32  per-slot read data
slot_wr_data_array  out  [N_SLOT] x 32  per-slot write data (mmio_wr_data broadcast)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: mmio_rd_data 0, mmio_rd_valid 0, ERR_STAT 0, ERR_CNT 0.
- Address decode: slot = addr[SW+4:5], reg = addr[4:0]. Address bits [10:SW+5] must be 0; otherwise the access is out-of-range.
- Legal access: an access is legal when it is in range, targets a populated slot other than N_SLOT-1, and does not assert both rd and wr.
- Strobes: combinational. For a legal access with mmio_cs=1, assert cs plus rd or wr for the addressed slot only, in the same cycle as the request.
- Read data register: on a legal read at cycle T, capture slot_rd_data_array[slot] at the clock edge ending T. mmio_rd_data and mmio_rd_valid=1 appear in T+1. mmio_rd_data holds its value until the next read.
- Back-to-back reads: a read every cycle is allowed, with a throughput of 1 per cycle.
- Unpopulated or out-of-range read: no slot strobe; returns 32'hFFFF_FFFF with the valid pulse at T+1; the access is logged.
- Unpopulated or out-of-range write: no strobe; the access is logged.
- Illegal rd+wr: mmio_cs=1 with rd=wr=1 drives no strobe, produces no valid pulse, and is logged with the PROTO bit set.
- Status slot (slot N_SLOT-1, internal):
  - reg 0 ERR_STAT: [31] VALID, [30] WR, [29] PROTO, [13:8] addr[10:5], [4:0] reg addr.
  - reg 1 ERR_CNT: zero-extended.
  - reg 2 ID: [15:8] N_SLOT-1, [7:0] 8'h01.
  - reg 3..31: read as 0.
  - Writing any value to reg 0 clears ERR_STAT and ERR_CNT. Writes to other status registers are ignored.
  - Reads of the status slot follow the same 1-cycle latency as slot reads.
- Logging: only the first error is captured; ERR_STAT is sticky while VALID=1. ERR_CNT increments on every error and saturates at all-ones.
- Simultaneous clear and new error: the clear applies first and the new error is then captured, so the result is VALID=1, CNT=1.
- Reset mid-read: reset forces mmio_rd_valid=0 next cycle; the pending read is dropped.

Optional Feature:
MMIO_REQ_PIPE_EN
- Defined: the request (cs, rd, wr, addr, wr_data) is registered before decode. Strobes occur at T+1 and read valid at T+2. Request order is preserved and throughput remains 1 per cycle. Reset clears the request register to idle.
- Undefined: combinational strobes and read latency 1, as described in Behaviour.

Decomposition:
- Package mmio_ctrl_pkg holds: REG_AW=5, STAT_ERR/STAT_CNT/STAT_ID register indices, ERR_STAT bit positions, the unpopulated read pattern 32'hFFFF_FFFF, and the ID version constant.
- One sub-module, mmio_err_log, holds ERR_STAT capture, the saturating counter and the clear/capture priority.

Test Plan:
1. Legal read, slot 2 returning 32'h0000_00A5: slot_mem_rd_array[2] pulses at T, mmio_rd_valid=1 with data 32'h0000_00A5 at T+1, and no other strobes.
2. Write 32'h1234 to slot 3 reg 1: slot_mem_wr_array[3]=1 and slot_reg_addr_array[3]=1 at T; ERR_CNT stays 0.
3. N_SLOT=16, SLOT_MASK bit 5=0; read slot 5 then write addr 11'h7E0: first access returns FFFF_FFFF at T+1; ERR_STAT = VALID, WR=0, addr field 5; ERR_CNT=2, and ERR_STAT is unchanged by the second error.
4. rd=wr=1 at slot 0: no strobes, no valid pulse; ERR_STAT PROTO=1, WR=1.
5. ERR_CNT_W=2 with 5 errors: ERR_CNT reads 3. Write reg 0 of the status slot in the same cycle as an error: VALID=1, CNT=1.
6. With MMIO_REQ_PIPE_EN, back-to-back reads of slots 0, 1, 2: valid pulses at T+2, T+3, T+4 with data in order; assert reset at T+3 and check that no valid pulse follows.
